burst_wordline_decoder: RTL and testbench
=========================================

// Module: burst_wordline_decoder
// PURPOSE
//  Registered, handshaked address-to-one-hot wordline decoder for the memory subsystem.
//  Accepts a start address plus burst length, then emits one one-hot line select per beat.
//  Auto-increments the address, with optional wrap-around.
//  Supports any line count N (not only powers of two) and downstream backpressure.
//  Sits between the FIFO/RAM control logic and the storage array wordlines.
// PARAMETERS
//  N          8   number of wordlines; N>=1, any integer
//  BURST_MAX  8   max beats per burst; power of two, >=1
//  Derived: AW = (N>1) ? $clog2(N) : 1
//  Derived: LW = (BURST_MAX>1) ? $clog2(BURST_MAX) : 1
// PORTS
//  clk         in   1   sole clock; one clock; reset is synchronous and active-high
//  rst         in   1   synchronous active-high reset
//  req_valid   in   1   burst request valid
//  req_ready   out  1   decoder can accept a request (IDLE only)
//  req_addr    in   AW  start wordline address
//  req_len     in   LW  beats-1 (0 = single beat)
//  req_wrap    in   1   1: address N-1 wraps to 0; 0: burst truncates at N-1
//  out_valid   out  1   out_onehot/out_addr hold a beat
//  out_ready   in   1   downstream accepts the beat
//  out_onehot  out  N   one-hot wordline select; all-zero when out_valid=0
//  out_addr    out  AW  binary address of the current beat
//  out_last    out  1   current beat is the final beat of the burst
//  err_range   out  1   one-cycle pulse: rejected start address or truncated burst
// BEHAVIOUR
//  Reset values: state=IDLE, req_ready=1, out_valid=0, out_onehot=0, out_addr=0,
//  out_last=0, err_range=0.
//  Reset mid-burst: at the next edge the decoder is IDLE; no out_last is produced.
//  FSM IDLE:
//   req_ready=1.
//   req_valid && req_addr<N: latch addr, len, wrap; go to BURST.
//   First beat: out_valid=1 in the cycle after acceptance (latency 1).
//   req_valid && req_addr>=N: err_range=1 next cycle; stay IDLE; no beat emitted.
//  FSM BURST:
//   req_ready=0.
//   out_onehot = 1<<out_addr, registered.
//   Beat transfers when out_valid && out_ready.
//   Stall (out_ready=0): all outputs hold exactly.
//   On transfer with beats remaining: out_addr increments.
//    wrap=1: N-1 -> 0.
//    wrap=0 at N-1: that beat is already marked out_last;
//    err_range pulses in the cycle it transfers; the burst ends.
//   out_last=1 when the remaining count is 0 or (!wrap && out_addr==N-1).
//   Transfer of the last beat: go to IDLE; out_valid=0 next cycle.
//   Hence one bubble cycle between back-to-back bursts.
//  Arithmetic:
//   Beat counter is LW bits and decrements to 0; no overflow is possible.
//   Address compare uses AW bits.
//   N==1: out_onehot is always 1'b1 when valid; out_addr stays 0.
//  Invariant: $onehot(out_onehot) whenever out_valid; out_onehot==0 otherwise.
// STRUCTURE
//  Package wordline_decoder_pkg:
//   typedef enum logic {IDLE, BURST} wld_state_t
//   localparam function for safe clog2 (returns >=1)
//  Sub-module wordline_decode_core: combinational, parametrised N.
//   addr + enable -> one-hot; all-zero for addr>=N or enable=0.
//   The top module instantiates it once and registers its output.
// TESTING
//  1. N=8, addr=3, len=3, wrap=0, out_ready=1 -> onehot 0x08,0x10,0x20,0x40; last on 0x40.
//  2. N=8, addr=6, len=3, wrap=1 -> 0x40,0x80,0x01,0x02; out_last on 0x02; err_range never.
//  3. N=8, addr=6, len=3, wrap=0 -> 0x40,0x80 (last), err_range pulse with 0x80, then IDLE.
//  4. N=6, req_addr=7 -> no out_valid, err_range one pulse, req_ready stays 1.
//  5. Burst with out_ready low 3 cycles on beat 2 -> outputs frozen, no beat lost or duplicated.
//  6. rst asserted during beat 2 of 4 -> next cycle out_valid=0, onehot=0, req_ready=1.

Source files
------------

// File: rtl/wordline_decoder_pkg.sv
// Shared types and helpers for the burst wordline decoder.
// Included by the decode core and the top-level decoder.
package wordline_decoder_pkg;

    typedef enum logic {IDLE, BURST} wld_state_t;

    function automatic int safe_clog2(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/wordline_decode_core.sv
// Combinational address-to-one-hot decoder for N wordlines.
// Addresses >= N and a low enable give an all-zero select.
module wordline_decode_core
    import wordline_decoder_pkg::*;
#(
    parameter  int N  = 8,
    localparam int AW = safe_clog2(N)
) (
    input  logic [AW-1:0] i_addr,
    input  logic          i_en,
    output logic [N-1:0]  o_onehot
);

    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (i_en && (i_addr == AW'(i))) begin
                o_onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/burst_wordline_decoder.sv
// Handshaked burst wordline decoder: one registered one-hot select per beat,
// auto-incrementing address with optional wrap or truncation at line N-1.
module burst_wordline_decoder
    import wordline_decoder_pkg::*;
#(
    parameter  int N         = 8,
    parameter  int BURST_MAX = 8,
    localparam int AW        = safe_clog2(N),
    localparam int LW        = safe_clog2(BURST_MAX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic [LW-1:0] req_len,
    input  logic          req_wrap,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_onehot,
    output logic [AW-1:0] out_addr,
    output logic          out_last,
    output logic          err_range
);

    localparam int            AW1  = AW + 1;
    localparam logic [AW-1:0] LAST = AW'(N - 1);
    localparam logic [AW:0]   NV   = AW1'(N);

    wld_state_t    r_state;
    logic          r_out_valid;
    logic [N-1:0]  r_onehot;
    logic [AW-1:0] r_addr;
    logic          r_last;
    logic [LW-1:0] r_cnt;
    logic          r_wrap;
    logic          r_trunc;
    logic          r_err_rej;

    logic          w_idle;
    logic          w_addr_ok;
    logic          w_accept;
    logic          w_reject;
    logic          w_xfer;
    logic          w_step;
    logic          w_load;
    logic [AW-1:0] w_step_addr;
    logic [AW-1:0] w_nxt_addr;
    logic [LW-1:0] w_nxt_cnt;
    logic          w_nxt_wrap;
    logic          w_nxt_end;
    logic          w_nxt_last;
    logic          w_nxt_trunc;
    logic [N-1:0]  w_dec;

    assign w_idle    = (r_state == IDLE);
    assign w_addr_ok = ({1'b0, req_addr} < NV);
    assign w_accept  = w_idle & req_valid & w_addr_ok;
    assign w_reject  = w_idle & req_valid & ~w_addr_ok;
    assign w_xfer    = r_out_valid & out_ready;
    assign w_step    = ~w_idle & w_xfer & ~r_last;
    assign w_load    = w_accept | w_step;

    // Only a wrapping burst can still step from line N-1.
    assign w_step_addr = (r_addr == LAST) ? '0 : r_addr + AW'(1);

    assign w_nxt_addr = w_accept ? req_addr : w_step_addr;
    assign w_nxt_cnt  = w_accept ? req_len  : r_cnt - LW'(1);
    assign w_nxt_wrap = w_accept ? req_wrap : r_wrap;
    assign w_nxt_end  = (w_nxt_addr == LAST);

    assign w_nxt_last  = (w_nxt_cnt == '0) | (~w_nxt_wrap & w_nxt_end);
    assign w_nxt_trunc = (w_nxt_cnt != '0) & ~w_nxt_wrap & w_nxt_end;

    wordline_decode_core #(
        .N (N)
    ) u_core (
        .i_addr   (w_nxt_addr),
        .i_en     (w_load),
        .o_onehot (w_dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_onehot    <= '0;
            r_addr      <= '0;
            r_last      <= 1'b0;
            r_cnt       <= '0;
            r_wrap      <= 1'b0;
            r_trunc     <= 1'b0;
            r_err_rej   <= 1'b0;
        end else begin
            r_err_rej <= w_reject;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state     <= BURST;
                        r_out_valid <= 1'b1;
                    end
                end
                BURST: begin
                    if (w_xfer && r_last) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_onehot    <= '0;
                        r_last      <= 1'b0;
                        r_trunc     <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (w_load) begin
                r_addr   <= w_nxt_addr;
                r_onehot <= w_dec;
                r_cnt    <= w_nxt_cnt;
                r_wrap   <= w_nxt_wrap;
                r_last   <= w_nxt_last;
                r_trunc  <= w_nxt_trunc;
            end
        end
    end

    assign req_ready  = w_idle;
    assign out_valid  = r_out_valid;
    assign out_onehot = r_onehot;
    assign out_addr   = r_addr;
    assign out_last   = r_last;
    // Truncation error fires only in the cycle the cut-off beat is taken.
    assign err_range  = r_err_rej | (w_xfer & r_trunc);

endmodule

// File: tb/tb_burst_wordline_decoder.sv
// Scoreboard bench for burst_wordline_decoder (N=8 main instance,
// N=6 instance for out-of-range and non-power-of-two wrap).
module tb_burst_wordline_decoder;

    localparam int NB = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_wrap;
    logic [2:0] req_addr, req_len;
    logic       out_valid, out_ready, out_last, err_range;
    logic [7:0] out_onehot;
    logic [2:0] out_addr;

    logic       req_valid_6, req_ready_6, req_wrap_6;
    logic [2:0] req_addr_6, req_len_6;
    logic       out_valid_6, out_ready_6, out_last_6, err_range_6;
    logic [5:0] out_onehot_6;
    logic [2:0] out_addr_6;

    int n_chk = 0;
    int n_err = 0;

    typedef struct packed {
        logic [7:0] oh;
        logic [2:0] addr;
        logic       last;
        logic       err;
    } beat_t;

    beat_t q[$];
    beat_t e;

    logic       pv_stall = 1'b0;
    logic [7:0] s_oh;
    logic [2:0] s_addr;
    logic       s_last;
    logic       rnd_rdy = 1'b0;

    always #5 clk = ~clk;

    burst_wordline_decoder #(.N(8), .BURST_MAX(8)) u_dut8 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_wrap   (req_wrap),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .out_addr   (out_addr),
        .out_last   (out_last),
        .err_range  (err_range)
    );

    burst_wordline_decoder #(.N(6), .BURST_MAX(8)) u_dut6 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid_6),
        .req_ready  (req_ready_6),
        .req_addr   (req_addr_6),
        .req_len    (req_len_6),
        .req_wrap   (req_wrap_6),
        .out_valid  (out_valid_6),
        .out_ready  (out_ready_6),
        .out_onehot (out_onehot_6),
        .out_addr   (out_addr_6),
        .out_last   (out_last_6),
        .err_range  (err_range_6)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_burst(input int a0, input int len, input bit wrap);
        int a;
        beat_t b;
        a = a0;
        for (int k = 0; k <= len; k++) begin
            b.oh   = 8'(1 << a);
            b.addr = 3'(a);
            b.last = (k == len) || (!wrap && a == NB - 1);
            b.err  = !wrap && (a == NB - 1) && (k != len);
            q.push_back(b);
            if (b.last) break;
            a = (a == NB - 1) ? 0 : a + 1;
        end
    endtask

    task automatic send(input int a, input int len, input bit wrap);
        for (int i = 0; i < 50 && !req_ready; i++) begin
            @(posedge clk); #1;
        end
        check("req_ready_wait", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = 3'(a);
        req_len   = 3'(len);
        req_wrap  = wrap;
        push_burst(a, len, wrap);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("latency1", out_valid, 1);
    endtask

    task automatic wait_done();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk); #1;
            out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (q.size() == 0 && req_ready && !out_valid) done = 1'b1;
        end
        out_ready = 1'b1;
        check("burst_done", done, 1);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            pv_stall = 1'b0;
        end else begin
            if (pv_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_onehot", out_onehot, s_oh);
                check("hold_addr", out_addr, s_addr);
                check("hold_last", out_last, s_last);
            end
            if (out_valid) check("is_onehot", $onehot(out_onehot), 1);
            else           check("idle_zero", out_onehot, 0);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("beat_onehot", out_onehot, e.oh);
                    check("beat_addr", out_addr, e.addr);
                    check("beat_last", out_last, e.last);
                    check("beat_err", err_range, e.err);
                end
            end else begin
                check("err_quiet", err_range, 0);
            end
            pv_stall = out_valid && !out_ready;
            s_oh     = out_onehot;
            s_addr   = out_addr;
            s_last   = out_last;
        end
    end

    logic [5:0] oh6 [4];

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_len = '0; req_wrap = 1'b0;
        out_ready = 1'b1;
        req_valid_6 = 1'b0; req_addr_6 = '0; req_len_6 = '0;
        req_wrap_6 = 1'b0; out_ready_6 = 1'b1;
        @(posedge clk); #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_onehot", out_onehot, 0);
        check("rst_addr", out_addr, 0);
        check("rst_last", out_last, 0);
        check("rst_err", err_range, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        send(3, 3, 1'b0); wait_done();
        send(6, 3, 1'b1); wait_done();
        send(6, 3, 1'b0); wait_done();
        send(7, 0, 1'b0); wait_done();
        send(0, 7, 1'b1); wait_done();

        // backpressure on beat 2
        send(1, 3, 1'b0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_done();

        rnd_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send($urandom_range(0, 7), $urandom_range(0, 7),
                 1'($urandom_range(0, 1)));
            wait_done();
        end
        rnd_rdy = 1'b0;

        // reset during beat 2 of 4
        send(0, 3, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        q.delete();
        @(posedge clk); #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_onehot", out_onehot, 0);
        check("midrst_ready", req_ready, 1);
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("midrst_still_idle", out_valid, 0);

        // N=6: out-of-range reject
        req_valid_6 = 1'b1; req_addr_6 = 3'd7; req_len_6 = 3'd2;
        @(posedge clk); #1;
        req_valid_6 = 1'b0;
        check("n6_rej_err", err_range_6, 1);
        check("n6_rej_valid", out_valid_6, 0);
        check("n6_rej_ready", req_ready_6, 1);
        @(posedge clk); #1;
        check("n6_rej_pulse", err_range_6, 0);
        check("n6_rej_novalid", out_valid_6, 0);

        // N=6: wrap 5 -> 0
        oh6[0] = 6'h10; oh6[1] = 6'h20; oh6[2] = 6'h01; oh6[3] = 6'h02;
        req_valid_6 = 1'b1; req_addr_6 = 3'd4; req_len_6 = 3'd3;
        req_wrap_6 = 1'b1;
        @(posedge clk); #1;
        req_valid_6 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("n6_valid", out_valid_6, 1);
            check("n6_onehot", out_onehot_6, oh6[k]);
            check("n6_last", out_last_6, (k == 3));
            check("n6_err", err_range_6, 0);
            @(posedge clk); #1;
        end
        check("n6_end_valid", out_valid_6, 0);
        check("n6_end_onehot", out_onehot_6, 0);
        check("n6_end_ready", req_ready_6, 1);

        check("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
